// File: rtl/me_pkg.sv
// Shared pixel geometry, row-sizing helper, window bus layout and FSM encoding
// for the motion-estimation reference-row feeder.
package me_pkg;

  localparam int PIX_W    = 8;
  localparam int BLK_PIX  = 16;
  localparam int EXT_PIX  = 3;
  localparam int WIN_PIX  = BLK_PIX + EXT_PIX;
  localparam int WORD_W   = 64;
  localparam int WORD_PIX = WORD_W / PIX_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // 19-pixel read window: pixel j of the window sits in bits [8j+7:8j].
  typedef struct packed {
    logic [EXT_PIX*PIX_W-1:0] ext;
    logic [BLK_PIX*PIX_W-1:0] blk;
  } win_t;

  // Words needed so that step SR_W can still see its pixel SR_W+18.
  function automatic int row_words(input int sr_w);
    return (sr_w + WIN_PIX + WORD_PIX - 1) / WORD_PIX;
  endfunction

endpackage

// File: rtl/me_line_buf.sv
// One search-row line buffer: word writes, a combinational 19-pixel window at any pixel offset,
// and a full flag. Window read is zero-latency; no backpressure (caller only writes when empty).
module me_line_buf
  import me_pkg::*;
#(
  parameter int WORDS = 7,
  parameter int IW    = 3,
  parameter int KW    = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [WORD_W-1:0] wr_dat,
  input  logic              set_full,
  input  logic              clr_full,
  input  logic [KW-1:0]     rd_off,
  output win_t              rd_win,
  output logic              full
);

  localparam int FLAT_W = WORDS * WORD_W;

  logic [WORD_W-1:0] mem [WORDS];
  logic [FLAT_W-1:0] flat;
  logic [FLAT_W-1:0] shifted;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  // The word being written this cycle is forwarded so the first step of a row
  // can be launched on the same edge that completes the row.
  always_comb begin
    flat = '0;
    for (int w = 0; w < WORDS; w++) begin
      flat[w*WORD_W +: WORD_W] = (wr_en && (wr_idx == IW'(w))) ? wr_dat : mem[w];
    end
  end

  assign shifted = flat >> (PIX_W * rd_off);
  assign rd_win  = win_t'(shifted[WIN_PIX*PIX_W-1:0]);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      full <= 1'b0;
    end else if (clr_full) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/me_ref_row_feeder.sv
// Ping-pong row assembler feeding the byte-shift window stage: last word of a row in at t, step 0 out at t+1.
// Input stalls via in_ready_o while both buffers are full; output has no backpressure (SR_W+1 gap-free steps).
module me_ref_row_feeder
  import me_pkg::*;
#(
  parameter int SR_W = 32,
  parameter int ROWS = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  input  logic [WORD_W-1:0]          in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [BLK_PIX*PIX_W-1:0]   blk_o,
  output logic [EXT_PIX*PIX_W-1:0]   ext_o,
  output logic                       out_valid_o,
  output logic                       row_start_o,
  output logic                       done_o,
  output logic                       busy_o
);

  localparam int ROW_WORDS = row_words(SR_W);
  localparam int KW        = $clog2(SR_W + 1);
  localparam int WW        = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam int RW        = $clog2(ROWS + 1);

  localparam logic [KW-1:0] K_LAST = KW'(SR_W);
  localparam logic [WW-1:0] W_LAST = WW'(ROW_WORDS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS);
  localparam logic [RW-1:0] R_END  = RW'(ROWS - 1);

  state_t        state;
  logic          fill_sel;
  logic          emit_sel;
  logic          emitting;
  logic [WW-1:0] fill_cnt;
  logic [RW-1:0] rows_filled;
  logic [RW-1:0] rows_emitted;
  logic [KW-1:0] k;

  logic [1:0]    full;
  logic [1:0]    full_eff;
  logic [1:0]    wr_en;
  logic [1:0]    set_full;
  logic [1:0]    clr_full;
  win_t          win [2];
  win_t          win_sel;

  logic          accept;
  logic          row_done;
  logic          last_step;
  logic          win_end;
  logic          nxt_vld;
  logic          nxt_sel;
  logic [KW-1:0] nxt_k;

  assign in_ready_o = (state == ST_RUN) && !full[fill_sel] && (rows_filled < R_LAST);
  assign accept     = in_valid_i && in_ready_o;
  assign row_done   = accept && (fill_cnt == W_LAST);
  assign last_step  = emitting && (k == K_LAST);
  assign win_end    = last_step && (rows_emitted == R_END);

  assign wr_en    = {accept & fill_sel,    accept & ~fill_sel};
  assign set_full = {row_done & fill_sel,  row_done & ~fill_sel};
  assign clr_full = {last_step & emit_sel, last_step & ~emit_sel};
  assign full_eff = full | set_full;

  for (genvar b = 0; b < 2; b++) begin : g_buf
    me_line_buf #(
      .WORDS (ROW_WORDS),
      .IW    (WW),
      .KW    (KW)
    ) u_buf (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .wr_en    (wr_en[b]),
      .wr_idx   (fill_cnt),
      .wr_dat   (in_data_i),
      .set_full (set_full[b]),
      .clr_full (clr_full[b]),
      .rd_off   (nxt_k),
      .rd_win   (win[b]),
      .full     (full[b])
    );
  end

  // Next emitted step: continue the row, hand over to the other buffer
  // back-to-back, or launch a freshly completed row.
  always_comb begin
    nxt_vld = 1'b0;
    nxt_sel = emit_sel;
    nxt_k   = '0;
    if (state == ST_RUN) begin
      if (emitting && !last_step) begin
        nxt_vld = 1'b1;
        nxt_k   = k + 1'b1;
      end else if (last_step) begin
        nxt_sel = !emit_sel;
        nxt_vld = !win_end && full_eff[!emit_sel];
      end else begin
        nxt_vld = full_eff[emit_sel];
      end
    end
  end

  assign win_sel = nxt_sel ? win[1] : win[0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= ST_IDLE;
      fill_sel     <= 1'b0;
      emit_sel     <= 1'b0;
      emitting     <= 1'b0;
      fill_cnt     <= '0;
      rows_filled  <= '0;
      rows_emitted <= '0;
      k            <= '0;
      blk_o        <= '0;
      ext_o        <= '0;
      out_valid_o  <= 1'b0;
      row_start_o  <= 1'b0;
      done_o       <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      done_o      <= 1'b0;
      busy_o      <= (state == ST_RUN) || start_i;
      out_valid_o <= nxt_vld;
      row_start_o <= nxt_vld && (nxt_k == '0);
      emitting    <= nxt_vld;
      k           <= nxt_k;
      emit_sel    <= nxt_sel;
      if (nxt_vld) begin
        blk_o <= win_sel.blk;
        ext_o <= win_sel.ext;
      end

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            fill_cnt <= row_done ? '0 : fill_cnt + 1'b1;
            if (row_done) begin
              fill_sel    <= !fill_sel;
              rows_filled <= rows_filled + 1'b1;
            end
          end
          if (last_step) begin
            rows_emitted <= rows_emitted + 1'b1;
          end
          if (win_end) begin
            state        <= ST_IDLE;
            done_o       <= 1'b1;
            fill_sel     <= 1'b0;
            emit_sel     <= 1'b0;
            fill_cnt     <= '0;
            rows_filled  <= '0;
            rows_emitted <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_ref_row_feeder.sv
// Directed bench for me_ref_row_feeder: cycle table for a one-row window, then hand sequences
// for back-to-back rows, input bubbles, start handling and mid-row reset.
module tb_me_ref_row_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start [2];
  logic         vld   [2];
  logic [63:0]  dat   [2];
  logic         rdy   [2];
  logic         ov    [2];
  logic         rs    [2];
  logic         dn    [2];
  logic         bz    [2];
  logic [127:0] blk   [2];
  logic [23:0]  ext   [2];

  int n_chk  = 0;
  int n_fail = 0;

  logic         h_rdy  [200];
  logic         h_vld  [200];
  logic         h_rs   [200];
  logic         h_done [200];
  logic [127:0] h_blk  [200];
  logic [23:0]  h_ext  [200];
  int           acc_cyc [32];
  int           n_acc;

  typedef struct {
    logic         start;
    logic         vld;
    logic [63:0]  dat;
    logic         e_rdy;
    logic         e_vld;
    logic         e_rs;
    logic         e_done;
    logic         e_busy;
    logic [127:0] e_blk;
    logic [23:0]  e_ext;
  } vec_t;

  vec_t tbl [43];

  always #5 clk = ~clk;

  me_ref_row_feeder #(.SR_W(32), .ROWS(1)) u_one (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start[0]), .in_data_i(dat[0]),
    .in_valid_i(vld[0]), .in_ready_o(rdy[0]), .blk_o(blk[0]), .ext_o(ext[0]),
    .out_valid_o(ov[0]), .row_start_o(rs[0]), .done_o(dn[0]), .busy_o(bz[0])
  );

  me_ref_row_feeder #(.SR_W(32), .ROWS(3)) u_three (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start[1]), .in_data_i(dat[1]),
    .in_valid_i(vld[1]), .in_ready_o(rdy[1]), .blk_o(blk[1]), .ext_o(ext[1]),
    .out_valid_o(ov[1]), .row_start_o(rs[1]), .done_o(dn[1]), .busy_o(bz[1])
  );

  function automatic logic [7:0] pix(input int r, input int n);
    return 8'((r * 56 + n) % 256);
  endfunction

  function automatic logic [63:0] pix_word(input int r, input int w);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = pix(r, 8*w + i);
    return v;
  endfunction

  function automatic logic [127:0] exp_blk(input int r, input int k);
    logic [127:0] v;
    for (int j = 0; j < 16; j++) v[8*j +: 8] = pix(r, k + j);
    return v;
  endfunction

  function automatic logic [23:0] exp_ext(input int r, input int k);
    return {pix(r, k + 18), pix(r, k + 17), pix(r, k + 16)};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start at cycle 0 (plus ignored start pulses at 20 and 60), stream row words,
  // record per-cycle outputs until done_o or until the optional reset cycle.
  task automatic run_feed(input int d, input bit bub, input int rst_at, output bit fin, output int ncyc);
    int acc;
    acc  = 0;
    fin  = 1'b0;
    ncyc = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(posedge clk); #1;
      start[d] = (c == 0) || (c == 20) || (c == 60);
      vld[d]   = bub ? (c % 2 == 1) : 1'b1;
      dat[d]   = pix_word(acc / 7, acc % 7);
      @(negedge clk);
      h_rdy[c]  = rdy[d];
      h_vld[c]  = ov[d];
      h_rs[c]   = rs[d];
      h_done[c] = dn[d];
      h_blk[c]  = blk[d];
      h_ext[c]  = ext[d];
      if (vld[d] && rdy[d] && acc < 32) begin
        acc_cyc[acc] = c;
        acc++;
      end
      ncyc = c + 1;
      if (dn[d]) fin = 1'b1;
      if (c == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("reset_mid_row_outputs",
            160'({rdy[d], ov[d], rs[d], dn[d], bz[d], blk[d], ext[d]}), 160'(0));
        fin = 1'b1;
      end
    end
    n_acc    = acc;
    start[d] = 1'b0;
    vld[d]   = 1'b0;
  endtask

  task automatic run_stats(input int ncyc, output int fv, output int nv, output int run,
                           output int nrs, output int dc);
    int cur;
    fv = -1; nv = 0; run = 0; nrs = 0; dc = -1; cur = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (h_vld[c]) begin
        if (fv < 0) fv = c;
        nv++;
        cur++;
        if (cur > run) run = cur;
      end else begin
        cur = 0;
      end
      if (h_rs[c]) nrs++;
      if (h_done[c]) dc = c;
    end
  endtask

  initial begin
    bit fin;
    int ncyc, fv, nv, run, nrs, dc, cnt, kk;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      vld[d]   = 1'b0;
      dat[d]   = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_state_dut%0d", d),
          160'({rdy[d], ov[d], rs[d], dn[d], bz[d], blk[d], ext[d]}), 160'(0));
    end
    rst_n = 1'b1;

    // One-row window (ROWS=1), cycle-exact expectations.
    for (int c = 0; c < 43; c++) begin
      tbl[c].start  = (c == 0);
      tbl[c].vld    = (c >= 1 && c <= 7);
      tbl[c].dat    = (c >= 1 && c <= 7) ? pix_word(0, c - 1) : 64'd0;
      tbl[c].e_rdy  = (c >= 1 && c <= 7);
      tbl[c].e_vld  = (c >= 8 && c <= 40);
      tbl[c].e_rs   = (c == 8);
      tbl[c].e_done = (c == 41);
      tbl[c].e_busy = (c >= 1 && c <= 41);
      kk = (c < 8) ? -1 : ((c > 40) ? 32 : c - 8);
      tbl[c].e_blk  = (kk < 0) ? 128'd0 : exp_blk(0, kk);
      tbl[c].e_ext  = (kk < 0) ? 24'd0 : exp_ext(0, kk);
    end
    for (int c = 0; c < 43; c++) begin
      @(posedge clk); #1;
      start[0] = tbl[c].start;
      vld[0]   = tbl[c].vld;
      dat[0]   = tbl[c].dat;
      @(negedge clk);
      chk($sformatf("row1_c%0d_ready", c), 160'(rdy[0]), 160'(tbl[c].e_rdy));
      chk($sformatf("row1_c%0d_valid", c), 160'(ov[0]), 160'(tbl[c].e_vld));
      chk($sformatf("row1_c%0d_row_start", c), 160'(rs[0]), 160'(tbl[c].e_rs));
      chk($sformatf("row1_c%0d_done", c), 160'(dn[0]), 160'(tbl[c].e_done));
      chk($sformatf("row1_c%0d_busy", c), 160'(bz[0]), 160'(tbl[c].e_busy));
      chk($sformatf("row1_c%0d_blk", c), 160'(blk[0]), 160'(tbl[c].e_blk));
      chk($sformatf("row1_c%0d_ext", c), 160'(ext[0]), 160'(tbl[c].e_ext));
    end
    start[0] = 1'b0;
    vld[0]   = 1'b0;

    // Back-to-back rows (ROWS=3), valid held high from the start cycle.
    run_feed(1, 1'b0, -1, fin, ncyc);
    run_stats(ncyc, fv, nv, run, nrs, dc);
    chk("b2b_done_reached", 160'(fin), 160'(1));
    chk("b2b_ready_at_start", 160'(h_rdy[0]), 160'(0));
    chk("b2b_ready_after_start", 160'(h_rdy[1]), 160'(1));
    chk("b2b_first_accept_cycle", 160'(acc_cyc[0]), 160'(1));
    chk("b2b_words_accepted", 160'(n_acc), 160'(21));
    chk("b2b_first_valid", 160'(fv), 160'(8));
    chk("b2b_valid_run", 160'(run), 160'(99));
    chk("b2b_valid_total", 160'(nv), 160'(99));
    chk("b2b_row_starts", 160'(nrs), 160'(3));
    chk("b2b_done_cycle", 160'(dc), 160'(107));
    cnt = 0;
    for (int c = 15; c <= 40; c++) if (h_rdy[c]) cnt++;
    chk("b2b_ready_low_both_full", 160'(cnt), 160'(0));
    chk("b2b_ready_after_clear", 160'(h_rdy[41]), 160'(1));
    chk("b2b_row1_k0_row_start", 160'(h_rs[41]), 160'(1));
    chk("b2b_row1_k0_blk", 160'(h_blk[41]), 160'(exp_blk(1, 0)));
    chk("b2b_row1_k32_ext", 160'(h_ext[73]), 160'(exp_ext(1, 32)));
    chk("b2b_row2_k0_blk", 160'(h_blk[74]), 160'(exp_blk(2, 0)));

    // Input bubbles on the one-row instance.
    run_feed(0, 1'b1, -1, fin, ncyc);
    run_stats(ncyc, fv, nv, run, nrs, dc);
    chk("bub_done_reached", 160'(fin), 160'(1));
    chk("bub_seventh_accept", 160'(acc_cyc[6]), 160'(13));
    chk("bub_first_valid", 160'(fv), 160'(14));
    chk("bub_valid_run", 160'(run), 160'(33));
    chk("bub_done_cycle", 160'(dc), 160'(47));
    chk("bub_k0_blk", 160'(h_blk[14]), 160'(exp_blk(0, 0)));
    chk("bub_k32_ext", 160'(h_ext[46]), 160'(exp_ext(0, 32)));

    // Reset at row 0, k=10, then restart with fresh data.
    run_feed(1, 1'b0, 18, fin, ncyc);
    chk("rst_pre_k10_valid", 160'(h_vld[18]), 160'(1));
    chk("rst_pre_k10_blk", 160'(h_blk[18]), 160'(exp_blk(0, 10)));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_feed(1, 1'b0, -1, fin, ncyc);
    run_stats(ncyc, fv, nv, run, nrs, dc);
    chk("restart_done_reached", 160'(fin), 160'(1));
    chk("restart_first_valid", 160'(fv), 160'(8));
    chk("restart_k0_blk", 160'(h_blk[8]), 160'(exp_blk(0, 0)));
    chk("restart_k0_ext", 160'(h_ext[8]), 160'(exp_ext(0, 0)));
    chk("restart_words_accepted", 160'(n_acc), 160'(21));
    chk("restart_valid_run", 160'(run), 160'(99));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/me_ref_row_feeder.md
# me_ref_row_feeder

Reference-row feeder for the motion-estimation search pipeline, directly upstream of the byte-shift window stage. It accepts reference pixels as a stream of 64-bit words and assembles one search-window row at a time into ping-pong line buffers. It then emits the row as a gap-free run of SR_W+1 cycles. Each cycle carries the current 16-pixel block and the next 3 pixels the shift stage pulls in, with the 128-bit block and 24-bit extension matching that stage's inputs.

## Interface
- SR_W, 32: horizontal search steps per row; a row is emitted for SR_W+1 cycles.
- ROWS, 32: rows per search window.
- ROW_WORDS, ceil((SR_W+19)/8): 64-bit words per row (7 for SR_W=32); derived, not overridden.
- clk_i  input  1  clock; one clock domain.
- rst_n_i  input  1  asynchronous, active-low reset.
- start_i  input  1  start a window; sampled only in IDLE.
- in_data_i  input  64  pixels 8w+0..8w+7; pixel i in bits [8i+7:8i].
- in_valid_i  input  1  in_data_i valid.
- in_ready_o  output  1  word accepted when in_valid_i && in_ready_o.
- blk_o  output  128  pixels k..k+15 of current row; byte j = pixel k+j.
- ext_o  output  24  {pixel k+18, pixel k+17, pixel k+16}.
- out_valid_o  output  1  blk_o/ext_o valid, step k.
- row_start_o  output  1  high with out_valid_o at k=0.
- done_o  output  1  one-cycle pulse after the last step of the last row.
- busy_o  output  1  high from start acceptance to done_o inclusive.

## Operation
- States: IDLE, RUN. IDLE→RUN on start_i; RUN→IDLE the cycle done_o is asserted.
- Start is ignored outside IDLE and while rst_n_i is low.
- Two line buffers, each ROW_WORDS×64 bits, with a full flag per buffer.
- Fill pointer: buffer select plus word counter 0..ROW_WORDS-1. Completing word ROW_WORDS-1 sets that buffer's full flag and toggles the fill select.
- in_ready_o = RUN && fill buffer not full && rows_filled < ROWS.
- in_ready_o depends on registered state only; there is no path from in_valid_i.
- Emit side: when the emit buffer is full and not emitting, start step k=0 on the next cycle.
- Step k increments every cycle to SR_W with no bubbles. No backpressure exists: downstream has no ready.
- After step SR_W: clear that buffer's full flag, toggle the emit select, and increment rows_emitted.
- If the other buffer is already full, its k=0 follows on the very next cycle, back-to-back.
- rows_emitted == ROWS after the last step: done_o pulses next cycle, state returns to IDLE, all counters clear.
- Extra input words beyond ROWS rows are not accepted (in_ready_o low).

## Timing
- Reset values:
  - in_ready_o, out_valid_o, row_start_o, done_o, busy_o = 0.
  - blk_o, ext_o = 0.
  - Both buffers empty; all counters 0; state IDLE.
- All outputs except in_ready_o are registered.
- Latency: last word of a row accepted at cycle t → k=0 at cycle t+1, provided no other row is emitting.
- Simultaneous clear of emit buffer and fill-complete of the other buffer: both take effect; next row k=0 at the following cycle.
- Fill and emit on the same buffer never overlap: a buffer is written only when empty.
- When outputs are not valid, blk_o and ext_o hold their last values.
- Reset mid-operation: outputs go to reset values immediately; partial rows are discarded; the next start needs fresh input.

## Structure
- Package me_pkg:
  - PIX_W=8, BLK_PIX=16, EXT_PIX=3.
  - row_words(sr_w) function.
  - State enum for IDLE/RUN.
- Sub-module me_line_buf, instantiated twice, provides:
  - synchronous word write (index, data);
  - combinational 19-pixel read window at pixel offset k;
  - full flag with set and clear.

## Test plan
SR_W=32, ROW_WORDS=7; input pixel n of row r has value (r*56+n) mod 256.
- **Single row:** ROWS=1, 7 contiguous words → 33 valid cycles.
  - Step k: blk_o byte0 = k, byte15 = k+15.
  - k=32: ext_o = {50,49,48}.
  - row_start_o only at k=0; done_o one cycle after k=32; busy_o drops with IDLE.
- **Back-to-back rows:** ROWS=3, in_valid_i held high → out_valid_o high for 99 consecutive cycles.
  - Row 1 k=0 blk_o byte0 = 56.
  - in_ready_o low while both buffers are full.
  - Exactly 21 words accepted.
- **Input bubbles:** in_valid_i toggling every cycle → k=0 exactly one cycle after the 7th accepted word; no gap inside a row.
- **Mid-row reset:** rst_n_i low at row 0, k=10.
  - All outputs are 0 at once.
  - After release, start_i with fresh data restarts at row 0, pixel 0.
- **Start handling:** start_i pulses during RUN are ignored, with no counter disturbance. start_i with in_valid_i already high → in_ready_o rises the cycle after start.
